// File: rtl/func_test_result_monitor.sv
// Functional-test result monitor.
// Snoops word writes to a 32-byte mailbox window on the core memory bus,
// captures the error registers, buffers log words in a show-ahead FIFO,
// runs a watchdog and latches a pass/fail/timeout verdict.
module func_test_result_monitor #(
  parameter logic [31:0] P_BASE_ADDR   = 32'h0002_0000,
  parameter int          P_LOG_DEPTH   = 8,
  parameter int          P_LOG_DEPTH_N = 3,
  parameter logic [31:0] P_TIMEOUT     = 32'd750000,
  parameter bit          P_BYTE_SWAP   = 1'b1
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iCLEAR,
  input  logic        iMEMORY_REQ,
  input  logic        iMEMORY_LOCK,
  input  logic [1:0]  iMEMORY_ORDER,
  input  logic        iMEMORY_RW,
  input  logic [31:0] iMEMORY_ADDR,
  input  logic [31:0] iMEMORY_DATA,
  output logic        oLOG_VALID,
  input  logic        iLOG_BUSY,
  output logic [31:0] oLOG_DATA,
  output logic        oLOG_OVERFLOW,
  output logic        oFINISH,
  output logic        oPASS,
  output logic        oFAIL,
  output logic        oTIMEOUT,
  output logic [31:0] oERR_TYPE,
  output logic [31:0] oERR_NUMBER,
  output logic [31:0] oERR_RESULT,
  output logic [31:0] oERR_EXPECT,
  output logic [31:0] oCYCLE_COUNT
);

  typedef enum logic [1:0] {RUN, DONE, TMO} stateT;

  localparam logic [P_LOG_DEPTH_N:0] PTR_ONE = {{P_LOG_DEPTH_N{1'b0}}, 1'b1};

  stateT stateReg, stateNext;
  logic  flagReg;
  logic  finishReg, finishNext;
  logic  passReg, passNext;
  logic  failReg, failNext;
  logic  timeoutReg, timeoutNext;
  logic  overflowReg;
  logic [31:0] errTypeReg, errNumberReg, errResultReg, errExpectReg;
  logic [31:0] cycleCountReg;

  logic [31:0] logMem [P_LOG_DEPTH];
  logic [P_LOG_DEPTH_N:0] wrPtrReg, rdPtrReg;

  logic [31:0] wrValue;
  logic [4:0]  wrOffset;
  logic        busWrite, running, finishWr, timeoutHit;
  logic        logEmpty, logFull, logPop, logPush, logPushOk;

  // Bus data may arrive byte-reversed; restore natural byte order.
  generate
    if (P_BYTE_SWAP) begin : gSwap
      for (genvar gi = 0; gi < 4; gi++) begin : gByte
        assign wrValue[8*gi +: 8] = iMEMORY_DATA[8*(3-gi) +: 8];
      end
    end else begin : gRaw
      assign wrValue = iMEMORY_DATA;
    end
  endgenerate

  assign busWrite = iMEMORY_REQ && !iMEMORY_LOCK && (iMEMORY_ORDER == 2'h2) &&
                    iMEMORY_RW && (iMEMORY_ADDR[31:5] == P_BASE_ADDR[31:5]);
  assign wrOffset   = iMEMORY_ADDR[4:0];
  assign running    = (stateReg == RUN);
  assign finishWr   = busWrite && running && (wrOffset == 5'h04);
  assign timeoutHit = (P_TIMEOUT != 32'd0) && (cycleCountReg == P_TIMEOUT - 32'd1);

  // Log FIFO status; the extra pointer MSB separates full from empty.
  assign logEmpty  = (wrPtrReg == rdPtrReg);
  assign logFull   = (wrPtrReg == {~rdPtrReg[P_LOG_DEPTH_N], rdPtrReg[P_LOG_DEPTH_N-1:0]});
  assign logPop    = !logEmpty && !iLOG_BUSY;
  assign logPush   = busWrite && (wrOffset == 5'h08);
  assign logPushOk = logPush && (!logFull || logPop);

  // Next state and verdict: a finish write beats a same-cycle timeout.
  always_comb begin
    stateNext   = stateReg;
    finishNext  = finishReg;
    passNext    = passReg;
    failNext    = failReg;
    timeoutNext = timeoutReg;
    if (running) begin
      if (finishWr) begin
        stateNext  = DONE;
        finishNext = 1'b1;
        passNext   = flagReg;
        failNext   = !flagReg;
      end else if (timeoutHit) begin
        stateNext   = TMO;
        finishNext  = 1'b1;
        passNext    = 1'b0;
        failNext    = 1'b1;
        timeoutNext = 1'b1;
      end
    end
  end

  // State, verdict, mailbox registers, watchdog and FIFO pointers.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      stateReg      <= RUN;
      flagReg       <= 1'b0;
      finishReg     <= 1'b0;
      passReg       <= 1'b0;
      failReg       <= 1'b0;
      timeoutReg    <= 1'b0;
      overflowReg   <= 1'b0;
      errTypeReg    <= '0;
      errNumberReg  <= '0;
      errResultReg  <= '0;
      errExpectReg  <= '0;
      cycleCountReg <= '0;
      wrPtrReg      <= '0;
      rdPtrReg      <= '0;
    end else if (iCLEAR) begin
      stateReg      <= RUN;
      flagReg       <= 1'b0;
      finishReg     <= 1'b0;
      passReg       <= 1'b0;
      failReg       <= 1'b0;
      timeoutReg    <= 1'b0;
      overflowReg   <= 1'b0;
      errTypeReg    <= '0;
      errNumberReg  <= '0;
      errResultReg  <= '0;
      errExpectReg  <= '0;
      cycleCountReg <= '0;
      wrPtrReg      <= '0;
      rdPtrReg      <= '0;
    end else begin
      stateReg   <= stateNext;
      finishReg  <= finishNext;
      passReg    <= passNext;
      failReg    <= failNext;
      timeoutReg <= timeoutNext;
      // The counter stops on the cycle that leaves RUN, so it freezes at the
      // value seen when the verdict was taken.
      if (stateNext == RUN && cycleCountReg != 32'hFFFF_FFFF)
        cycleCountReg <= cycleCountReg + 32'd1;
      if (busWrite && running) begin
        case (wrOffset)
          5'h00:   flagReg      <= wrValue[0];
          5'h0C:   errTypeReg   <= wrValue;
          5'h10:   errNumberReg <= wrValue;
          5'h14:   errResultReg <= wrValue;
          5'h18:   errExpectReg <= wrValue;
          default: ;
        endcase
      end
      if (logPop)
        rdPtrReg <= rdPtrReg + PTR_ONE;
      if (logPushOk)
        wrPtrReg <= wrPtrReg + PTR_ONE;
      if (logPush && logFull && !logPop)
        overflowReg <= 1'b1;
    end
  end

  // Log storage; contents need no reset because the pointers define validity.
  always_ff @(posedge iCLOCK) begin
    if (logPushOk)
      logMem[wrPtrReg[P_LOG_DEPTH_N-1:0]] <= wrValue;
  end

  assign oLOG_VALID    = !logEmpty;
  assign oLOG_DATA     = logEmpty ? 32'd0 : logMem[rdPtrReg[P_LOG_DEPTH_N-1:0]];
  assign oLOG_OVERFLOW = overflowReg;
  assign oFINISH       = finishReg;
  assign oPASS         = passReg;
  assign oFAIL         = failReg;
  assign oTIMEOUT      = timeoutReg;
  assign oERR_TYPE     = errTypeReg;
  assign oERR_NUMBER   = errNumberReg;
  assign oERR_RESULT   = errResultReg;
  assign oERR_EXPECT   = errExpectReg;
  assign oCYCLE_COUNT  = cycleCountReg;

endmodule

// File: doc/func_test_result_monitor.md
Name: func_test_result_monitor

Overview:
Synthesizable, parametrised successor to the functional-level testbench's assertion monitor. It snoops the core's memory bus and decodes word writes to a mailbox window (flag, finish, log, error type/number/result/expect). It buffers log words in a FIFO, runs a watchdog cycle counter and reports a latched pass/fail/timeout verdict. It sits beside the memory model in simulation benches and in FPGA bring-up builds, where its outputs drive LEDs or a debug UART.

Parameters:
P_BASE_ADDR, 32'h0002_0000, mailbox base address; low 5 bits must be zero.
P_LOG_DEPTH, 8, log FIFO entries; power of two, 2..64.
P_LOG_DEPTH_N, 3, log2(P_LOG_DEPTH).
P_TIMEOUT, 32'd750000, RUN cycles before the watchdog fires; 0 disables the watchdog.
P_BYTE_SWAP, 1, 1 = bus data is byte-reversed and is swapped back before use; 0 = used as-is.

Ports:
iCLOCK  in  1  clock
inRESET  in  1  asynchronous active-low reset
iCLEAR  in  1  synchronous re-arm: returns to RUN and clears all state
iMEMORY_REQ  in  1  snooped bus request
iMEMORY_LOCK  in  1  snooped bus lock; 1 = request not accepted
iMEMORY_ORDER  in  2  snooped access size; 2'h2 = word
iMEMORY_RW  in  1  snooped direction; 1 = write
iMEMORY_ADDR  in  32  snooped address
iMEMORY_DATA  in  32  snooped write data
oLOG_VALID  out  1  log FIFO not empty
iLOG_BUSY  in  1  consumer stall
oLOG_DATA  out  32  FIFO head word (show-ahead)
oLOG_OVERFLOW  out  1  sticky: a log word was dropped
oFINISH  out  1  verdict latched
oPASS  out  1  finished with flag set
oFAIL  out  1  finished with flag clear, or timed out
oTIMEOUT  out  1  watchdog fired
oERR_TYPE  out  32  last error-type word
oERR_NUMBER  out  32  last error-index word
oERR_RESULT  out  32  last result word
oERR_EXPECT  out  32  last expect word
oCYCLE_COUNT  out  32  RUN cycles elapsed; saturates at 32'hFFFF_FFFF

Behaviour:
- Reset (async, inRESET=0): state RUN; all outputs, registers, FIFO pointers, flag and counter are 0.
- Accepted write: iMEMORY_REQ & !iMEMORY_LOCK & iMEMORY_ORDER==2'h2 & iMEMORY_RW & ADDR[31:5]==P_BASE_ADDR[31:5], sampled at the rising edge.
  - Value V = byte-swapped iMEMORY_DATA when P_BYTE_SWAP=1, otherwise raw data.
- Decode by ADDR[4:0]:
  - 0x00: flag <= V[0].
  - 0x04: finish.
  - 0x08: push V into the log FIFO.
  - 0x0C: oERR_TYPE <= V.
  - 0x10: oERR_NUMBER <= V.
  - 0x14: oERR_RESULT <= V.
  - 0x18: oERR_EXPECT <= V.
  - Any other offset: ignored.
- Latency: a register write is visible on outputs the cycle after the sampling edge. A log push raises oLOG_VALID the next cycle when the FIFO was empty.
- State machine: RUN, DONE, TMO.
  - RUN -> DONE on an accepted finish write: oFINISH=1, oPASS=flag, oFAIL=!flag.
  - RUN -> TMO when P_TIMEOUT!=0 and oCYCLE_COUNT==P_TIMEOUT-1 with no finish that cycle: oFINISH=1, oTIMEOUT=1, oFAIL=1, oPASS=0.
  - Finish write in the same cycle as the timeout: finish wins, next state DONE.
  - DONE and TMO hold until iCLEAR or reset. Mailbox writes in these states are ignored, except log pushes, which remain accepted.
- oCYCLE_COUNT increments every cycle in RUN and freezes in DONE/TMO.
- Flag and finish written in the same cycle are impossible (one address per cycle). A finish with the flag never written reports fail.
- FIFO:
  - Pop when oLOG_VALID & !iLOG_BUSY.
  - Push while full and no pop in the same cycle: word dropped, oLOG_OVERFLOW <= 1 (sticky).
  - Push while full with a pop in the same cycle: push accepted, no overflow.
  - Push and pop on an empty FIFO: the push is stored, nothing is popped.
  - Pointers wrap modulo P_LOG_DEPTH; full/empty use an extra pointer MSB.
- iCLEAR has priority over any same-cycle bus event: state RUN, counter 0, flag 0, error registers 0, FIFO emptied, overflow 0, verdict outputs 0.
- Reset asserted mid-operation clears everything immediately (async); operation resumes in RUN after release.

Test Plan:
1. Pass: write 0x00 data 32'h0100_0000 (swap on), then 0x04 -> next cycle oFINISH=1, oPASS=1, oFAIL=0, oCYCLE_COUNT frozen.
2. Fail capture: write 0x0C=32'h0300_0000, 0x10=32'h0700_0000, 0x14=32'hEFBE_ADDE, 0x18=32'h0DF0_ADBA, then 0x04 with no flag -> oERR_TYPE=3, oERR_NUMBER=7, oERR_RESULT=32'hDEAD_BEEF, oERR_EXPECT=32'hBAAD_F00D, oFAIL=1.
3. Log FIFO: iLOG_BUSY=1, push 9 words to 0x08 with P_LOG_DEPTH=8 -> 8 stored, oLOG_OVERFLOW=1. Release busy -> words 1..8 pop in order, oLOG_VALID then falls.
4. Filtering: writes with LOCK=1, ORDER=2'h1, RW=0 or ADDR=32'h0003_0004 -> no register change, no finish.
5. Timeout: P_TIMEOUT=100, no writes -> oTIMEOUT=oFAIL=oFINISH=1 after 100 RUN cycles, oCYCLE_COUNT=99. Repeat with finish at cycle 99 -> DONE, oTIMEOUT=0.
6. Re-arm: after DONE, assert iCLEAR together with a finish write -> all verdict outputs 0, state RUN; a later flag+finish sequence passes normally.
